// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the multi-cycle divider: FSM states and the
// div_ctrl operation encodings also used by the instruction decoder.
package div_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIXUP,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CTRL_DIV  = 2'b00,
    CTRL_DIVU = 2'b01,
    CTRL_REM  = 2'b10,
    CTRL_REMU = 2'b11
  } div_ctrl_e;

  function automatic logic is_signed_op(input logic [1:0] ctrl);
    return (ctrl == CTRL_DIV) || (ctrl == CTRL_REM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] ctrl);
    return (ctrl == CTRL_REM) || (ctrl == CTRL_REMU);
  endfunction

endpackage

// File: rtl/div_sequencer_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and record the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // NOTE: combinational logic uses blocking '=' and assigns every output on
  // every path, so no latch can be inferred.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_i};
    // The partial remainder stays below the divisor, so the borrow bit alone
    // tells whether the trial subtraction went negative.
    if (trial[WIDTH]) begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider that stalls the front of the pipeline while
// a DIV/DIVU/REM/REMU instruction sits in execute.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_en_e,
  input  logic [1:0]       div_ctrl_e,
  input  logic [WIDTH-1:0] op_a_e,
  input  logic [WIDTH-1:0] op_b_e,
  input  logic             flush,
  output logic             div_stall,
  output logic             div_done_e,
  output logic [WIDTH-1:0] div_result_e
);

  localparam int CNT_W = $clog2(ITERS) + 1;

  state_e             state_q, state_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]   step_rem, step_quo;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               signed_op, rem_op, div_zero, overflow;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Sign flags are only set for signed ops, so magnitudes pass unsigned
  // operands through unchanged.
  assign signed_op = is_signed_op(ctrl_q);
  assign rem_op    = is_rem_op(ctrl_q);
  assign a_mag     = sign_a_q ? -a_q : a_q;
  assign b_mag     = sign_b_q ? -b_q : b_q;
  assign div_zero  = (b_q == '0);
  assign overflow  = signed_op && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    div_stall  = 1'b0;
    div_done_e = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (div_en_e && !flush) begin
          div_stall = 1'b1;
          ctrl_d    = div_ctrl_e;
          a_d       = op_a_e;
          b_d       = op_b_e;
          sign_a_d  = op_a_e[WIDTH-1] & is_signed_op(div_ctrl_e);
          sign_b_d  = op_b_e[WIDTH-1] & is_signed_op(div_ctrl_e);
          state_d   = S_PREP;
        end
      end
      S_PREP: begin
        div_stall = 1'b1;
        rem_d     = '0;
        cnt_d     = '0;
        quo_d     = a_mag;
        dvsr_d    = b_mag;
        if (div_zero) begin
          result_d = rem_op ? a_q : '1;
          state_d  = S_DONE;
        end else if (overflow) begin
          result_d = rem_op ? '0 : a_q;
          state_d  = S_DONE;
        end else begin
          state_d  = S_ITER;
        end
      end
      S_ITER: begin
        div_stall = 1'b1;
        rem_d     = step_rem;
        quo_d     = step_quo;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        div_stall = 1'b1;
        if (rem_op) result_d = sign_a_q ? -rem_q : rem_q;
        else        result_d = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        div_done_e = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush abandons the operation; the result register keeps its old value.
    if (flush) begin
      state_d    = S_IDLE;
      result_d   = result_q;
      div_done_e = 1'b0;
    end
    if (rst) begin
      div_stall  = 1'b0;
      div_done_e = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign div_result_e = result_q;

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter: ITERS, default WIDTH, number of restoring-division iterations.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: div_en_e  input  1  the execute-stage instruction is a divide or remainder.
REQ-006 Port: div_ctrl_e  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 Port: op_a_e  input  WIDTH  dividend, already forwarded.
REQ-008 Port: op_b_e  input  WIDTH  divisor, already forwarded.
REQ-009 Port: flush  input  1  abort any operation in progress.
REQ-010 Port: div_stall  output  1  hold the fetch, decode and execute pipeline registers.
REQ-011 Port: div_done_e  output  1  result valid this cycle; the instruction may advance.
REQ-012 Port: div_result_e  output  WIDTH  quotient or remainder.

Function
REQ-013 The block SHALL use five FSM states: IDLE, PREP, ITER, FIXUP, DONE.
REQ-014 In IDLE with div_en_e=1 and flush=0, the block SHALL latch operands, div_ctrl_e and operand signs, then go to PREP (cycle T).
REQ-015 PREP (T+1) SHALL load magnitudes for signed ops and operands unchanged for unsigned ops; it SHALL clear the partial remainder and the counter.
REQ-016 From PREP, divide-by-zero or signed overflow (most-negative / -1) SHALL go directly to DONE; all other cases SHALL go to ITER.
REQ-017 ITER SHALL perform one restoring step per cycle (shift, trial subtract, set quotient bit) for exactly ITERS cycles (T+2..T+ITERS+1).
REQ-018 The iteration counter SHALL be log2(ITERS)+1 bits wide and saturate-free; ITER SHALL exit to FIXUP when the counter reaches ITERS-1.
REQ-019 FIXUP SHALL negate the quotient if the operand signs differ (DIV), and negate the remainder if the dividend is negative (REM); unsigned ops SHALL pass unchanged.
REQ-020 DONE SHALL assert div_done_e=1 for exactly one cycle (T+ITERS+3, i.e. T+35 at default), then go to IDLE.
REQ-021 div_stall SHALL be combinational: 1 when (IDLE and div_en_e=1 and flush=0) or state is PREP, ITER or FIXUP; 0 in DONE and otherwise.
REQ-022 div_en_e seen in DONE SHALL be ignored; a new divide SHALL start only from IDLE, so back-to-back divides each take the full latency.
REQ-023 Divide by zero SHALL give quotient all-ones and remainder equal to the dividend, for both signed and unsigned ops.
REQ-024 Signed overflow SHALL give quotient 0x80000000 and remainder 0.
REQ-025 Special cases SHALL reach DONE at T+2.
REQ-026 flush=1 in any state SHALL force IDLE on the next edge with div_done_e=0; flush takes priority over a start in IDLE.
REQ-027 div_result_e SHALL be driven from a register updated only on entry to DONE and held otherwise.
REQ-028 Operands latched at T SHALL be used throughout; changes on op_a_e/op_b_e after T SHALL have no effect.

Reset
REQ-029 rst SHALL force IDLE, counter 0, all datapath registers 0 and div_result_e=0, asynchronously.
REQ-030 While rst=1, div_stall=0 and div_done_e=0; reset mid-operation SHALL abandon the operation without a done pulse.

Structure
REQ-031 The shared package SHALL hold the FSM state enum and the div_ctrl encodings (DIV, DIVU, REM, REMU), for use by the decoder as well.
REQ-032 One combinational sub-module, div_step, SHALL implement a single restoring iteration (remainder/quotient in, remainder/quotient out).
REQ-033 The block SHALL be instantiated beside the execute stage, and its div_stall/div_done_e SHALL feed the hazard unit.

Verification
REQ-034 DIVU 100/7 at T -> div_stall=1 T..T+34, div_done_e=1 at T+35, result 14; REMU same operands -> 2.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF (-1), both at T+35.
REQ-036 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5, both at T+2.
REQ-037 Flush at T+10 (ITER) -> IDLE at T+11, div_stall=0, no done pulse; a new divide then starts cleanly.
REQ-038 Reset pulse at T+20 -> all outputs 0 immediately; div_en_e held high after reset -> fresh operation, done at full latency.
REQ-039 Two consecutive DIVU instructions (div_en_e stays high through DONE) -> two distinct done pulses 36 cycles apart with correct results.
